flag_conditioner: RTL

Input-conditioning stage that sits directly upstream of the mealy FSM and drives its flag input. It synchronises an asynchronous raw level into clk and debounces it with a qualification counter. It outputs a clean level, one-cycle rise and fall pulses, and a saturating glitch counter used for bring-up and debug.

---
 rtl/flag_cond_pkg.sv | 17 +
 rtl/sync_chain.sv | 24 ++
 rtl/flag_conditioner.sv | 124 ++++++++++++
 3 files changed

// File: rtl/flag_cond_pkg.sv
// rtl/flag_cond_pkg.sv - shared types and helpers for the flag conditioner
package flag_cond_pkg;

  // Debounce FSM states; STABLE_x hold a settled level, QUAL_x count towards a change.
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    QUAL_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    QUAL_LOW    = 2'd3
  } state_t;

  // Width of a counter able to hold 0..debounce_cycles.
  function automatic int cnt_width(input int debounce_cycles);
    return (debounce_cycles < 1) ? 1 : $clog2(debounce_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - multi-flop synchroniser for an asynchronous level
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  // Plain shift chain; no logic between stages so metastability can resolve.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/flag_conditioner.sv
// rtl/flag_conditioner.sv - synchronise, debounce and edge-detect a raw flag level
module flag_conditioner
  import flag_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GLITCH_W        = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                raw_in,
  output logic                flag_out,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int                  CW         = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]       CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]       CNT_ONE    = CW'(1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;
  localparam bit                  SINGLE     = (DEBOUNCE_CYCLES == 1);

  logic                s;
  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic                flag_q;
  logic                rise_q;
  logic                fall_q;
  logic [GLITCH_W-1:0] glitch_q;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i (clk),
    .rst_ni(reset),
    .d_i   (raw_in),
    .q_o   (s)
  );

  // Debounce FSM: cnt_q holds how many consecutive differing samples have been seen;
  // the sample that would make it DEBOUNCE_CYCLES commits the new level instead.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= STABLE_LOW;
      cnt_q    <= '0;
      flag_q   <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      unique case (state_q)
        STABLE_LOW: begin
          if (s) begin
            if (SINGLE) begin
              state_q <= STABLE_HIGH;
              flag_q  <= 1'b1;
              rise_q  <= 1'b1;
            end else begin
              state_q <= QUAL_HIGH;
              cnt_q   <= CNT_ONE;
            end
          end
        end
        QUAL_HIGH: begin
          if (s) begin
            if (cnt_q == CNT_LAST) begin
              state_q <= STABLE_HIGH;
              flag_q  <= 1'b1;
              rise_q  <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            if (glitch_q != GLITCH_MAX) glitch_q <= glitch_q + 1'b1;
          end
        end
        STABLE_HIGH: begin
          if (!s) begin
            if (SINGLE) begin
              state_q <= STABLE_LOW;
              flag_q  <= 1'b0;
              fall_q  <= 1'b1;
            end else begin
              state_q <= QUAL_LOW;
              cnt_q   <= CNT_ONE;
            end
          end
        end
        QUAL_LOW: begin
          if (!s) begin
            if (cnt_q == CNT_LAST) begin
              state_q <= STABLE_LOW;
              flag_q  <= 1'b0;
              fall_q  <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            state_q <= STABLE_HIGH;
            cnt_q   <= '0;
            if (glitch_q != GLITCH_MAX) glitch_q <= glitch_q + 1'b1;
          end
        end
        default: begin
          state_q <= STABLE_LOW;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign flag_out   = flag_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign glitch_cnt = glitch_q;

endmodule
